// File: rtl/jesd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jesd_pkg
// Brief   : Shared types and default timing constants for the JESD TX link
//           bring-up controller.
// Revision: 1.0 - initial release
// ============================================================================
package jesd_pkg;

   // Link controller state encoding, also exported on the link_state port
   typedef enum logic [2:0] {
      LS_IDLE       = 3'd0,
      LS_RESET_CORE = 3'd1,
      LS_WAIT_CGS   = 3'd2,
      LS_WAIT_ILAS  = 3'd3,
      LS_DATA       = 3'd4,
      LS_FAULT      = 3'd5
   } link_state_t;

   // Default bring-up timing
   localparam int DEF_RST_CYCLES   = 8;
   localparam int DEF_CGS_TIMEOUT  = 256;
   localparam int DEF_ILAS_TIMEOUT = 256;
   localparam int DEF_DROP_TOL     = 16;
   localparam int DEF_MAX_RETRIES  = 3;

   // Bits needed to hold 0..v-1, never less than one bit
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage
`default_nettype wire

// File: rtl/jesd_timer.sv
`default_nettype none
// ============================================================================
// Module  : jesd_timer
// Brief   : Clearable up-counter that saturates at a terminal value and flags
//           when that value has been reached.
// Revision: 1.0 - initial release
// ============================================================================
module jesd_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [WIDTH-1:0] term,
   output logic             tc
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: clear wins, otherwise count up and hold at the terminal value
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q < term)) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q >= term);

endmodule
`default_nettype wire

// File: rtl/jesd_tx_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : jesd_tx_link_ctrl
// Brief   : JESD204 transmit link bring-up sequencer: core reset, CGS and ILAS
//           waits with timeouts, data-phase drop monitoring, bounded retries
//           and a sticky fault.
// Revision: 1.0 - initial release
// ============================================================================
module jesd_tx_link_ctrl
   import jesd_pkg::*;
#(
   parameter int RST_CYCLES   = DEF_RST_CYCLES,
   parameter int CGS_TIMEOUT  = DEF_CGS_TIMEOUT,
   parameter int ILAS_TIMEOUT = DEF_ILAS_TIMEOUT,
   parameter int DROP_TOL     = DEF_DROP_TOL,
   parameter int MAX_RETRIES  = DEF_MAX_RETRIES
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             enable,
   input  logic                             jesd_cgs_done,
   input  logic                             jesd_ilas_done,
   input  logic                             jesd_link_up,
   output logic                             jesd_tx_rst_n,
   output logic                             jesd_tx_en,
   output logic                             payload_en,
   output link_state_t                      link_state,
   output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
   output logic                             fault
);

   localparam int RTY_W   = $clog2(MAX_RETRIES+1);
   localparam int TMR_MAX = (RST_CYCLES > CGS_TIMEOUT) ?
                            ((RST_CYCLES > ILAS_TIMEOUT) ? RST_CYCLES : ILAS_TIMEOUT) :
                            ((CGS_TIMEOUT > ILAS_TIMEOUT) ? CGS_TIMEOUT : ILAS_TIMEOUT);
   localparam int TMR_W   = clog2_min1(TMR_MAX);
   localparam int DRP_W   = clog2_min1(DROP_TOL);

   link_state_t      state_q, state_d;
   logic [RTY_W-1:0] retry_q, retry_d;
   logic             rst_n_q, rst_n_d;
   logic             tx_en_q, tx_en_d;
   logic             fault_q, fault_d;

   logic             all_ok;
   logic             fail;
   logic             tmr_clr, tmr_tc;
   logic [TMR_W-1:0] tmr_term;
   logic             drp_clr, drp_tc;

   assign all_ok = jesd_cgs_done & jesd_ilas_done & jesd_link_up;

   // Terminal value of the shared state timer depends on the phase being timed
   always_comb begin
      tmr_term = '0;
      case (state_q)
         LS_RESET_CORE: tmr_term = TMR_W'(RST_CYCLES - 1);
         LS_WAIT_CGS:   tmr_term = TMR_W'(CGS_TIMEOUT - 1);
         LS_WAIT_ILAS:  tmr_term = TMR_W'(ILAS_TIMEOUT - 1);
         default:       tmr_term = '0;
      endcase
   end

   // State timer restarts on every state change and is parked in IDLE
   assign tmr_clr = (state_q == LS_IDLE) || (state_d != state_q);

   jesd_timer #(.WIDTH(TMR_W)) u_state_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (tmr_clr),
      .inc  (1'b1),
      .term (tmr_term),
      .tc   (tmr_tc)
   );

   // Drop counter only runs across consecutive bad-status cycles in DATA
   assign drp_clr = (state_q != LS_DATA) || all_ok;

   jesd_timer #(.WIDTH(DRP_W)) u_drop_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (drp_clr),
      .inc  (1'b1),
      .term (DRP_W'(DROP_TOL - 1)),
      .tc   (drp_tc)
   );

   // Next-state, retry accounting and registered output values
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      fail    = 1'b0;

      if (!enable) begin
         state_d = LS_IDLE;
         retry_d = '0;
      end else begin
         case (state_q)
            LS_IDLE:       state_d = LS_RESET_CORE;
            LS_RESET_CORE: if (tmr_tc) state_d = LS_WAIT_CGS;
            LS_WAIT_CGS: begin
               // done is tested first so it beats a same-cycle timeout
               if (jesd_cgs_done)  state_d = LS_WAIT_ILAS;
               else if (tmr_tc)    fail    = 1'b1;
            end
            LS_WAIT_ILAS: begin
               if (all_ok)              state_d = LS_DATA;
               else if (!jesd_cgs_done) fail    = 1'b1;
               else if (tmr_tc)         fail    = 1'b1;
            end
            LS_DATA:       if (!all_ok && drp_tc) fail = 1'b1;
            LS_FAULT:      state_d = LS_FAULT;
            default:       state_d = LS_IDLE;
         endcase

         if (fail) begin
            if ((int'(retry_q) + 1) == MAX_RETRIES) begin
               state_d = LS_FAULT;
               retry_d = RTY_W'(MAX_RETRIES);
            end else begin
               state_d = LS_RESET_CORE;
               retry_d = retry_q + RTY_W'(1);
            end
         end

         // A successful bring-up forgives earlier failures
         if ((state_d == LS_DATA) && (state_q != LS_DATA)) begin
            retry_d = '0;
         end
      end

      rst_n_d = (state_d == LS_WAIT_CGS) || (state_d == LS_WAIT_ILAS) ||
                (state_d == LS_DATA);
      tx_en_d = rst_n_d;
      fault_d = (state_d == LS_FAULT);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LS_IDLE;
         retry_q <= '0;
         rst_n_q <= 1'b0;
         tx_en_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         retry_q <= retry_d;
         rst_n_q <= rst_n_d;
         tx_en_q <= tx_en_d;
         fault_q <= fault_d;
      end
   end

   assign link_state    = state_q;
   assign retry_cnt     = retry_q;
   assign jesd_tx_rst_n = rst_n_q;
   assign jesd_tx_en    = tx_en_q;
   assign fault         = fault_q;
   // Unregistered so payload stops in the very cycle a status drops
   assign payload_en    = (state_q == LS_DATA) & all_ok;

endmodule
`default_nettype wire
